// File: rtl/cookie_grid_if.sv
// cookie_grid_if: control, load, status and dump signals of the cookie_grid cell array
interface cookie_grid_if #(parameter int CNT_W = 16);
  logic en;
  logic load_en;
  logic load_bit;
  logic out_bit;
  logic step_start;
  logic [CNT_W-1:0] step_count;
  logic busy;
  logic done;
  logic stable;
  logic [CNT_W-1:0] gen_count;
  logic dump_start;
  logic dump_bit;
  logic dump_valid;
  modport master (
    output en, load_en, load_bit, step_start, step_count, dump_start,
    input out_bit, busy, done, stable, gen_count, dump_bit, dump_valid
  );
  modport slave (
    input en, load_en, load_bit, step_start, step_count, dump_start,
    output out_bit, busy, done, stable, gen_count, dump_bit, dump_valid
  );
endinterface

// File: rtl/cookie_grid.sv
// cookie_grid: B3/S23 life array with serial load, run controller and snapshot dump
module cookie_grid #(
  parameter int WIDTH = 16,
  parameter int HEIGHT = 16,
  parameter int WRAP = 0,
  parameter int STOP_ON_STABLE = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  cookie_grid_if.slave bus
);
  localparam int N = WIDTH * HEIGHT;
  localparam int DW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] grid, grid_n, nxt, shadow;
  logic [CNT_W-1:0] rem, rem_n, gen, gen_n;
  logic stable_q, stable_n, done_q, done_n, same, dv;
  logic [DW-1:0] dcnt;
  function automatic logic nb(input logic [N-1:0] g, input int xx, input int yy);
    int wx, wy;
    wx = (WRAP != 0) ? (xx + WIDTH) % WIDTH : xx;
    wy = (WRAP != 0) ? (yy + HEIGHT) % HEIGHT : yy;
    return (wx < 0 || wx >= WIDTH || wy < 0 || wy >= HEIGHT) ? 1'b0 : g[wy*WIDTH + wx];
  endfunction
  for (genvar y = 0; y < HEIGHT; y++) begin : g_row
    for (genvar x = 0; x < WIDTH; x++) begin : g_col
      logic [3:0] cnt;
      // live-neighbour count of this cell
      always_comb begin
        cnt = '0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) cnt = cnt + {3'b0, nb(grid, x + dx, y + dy)};
      end
      assign nxt[y*WIDTH + x] = cnt == 4'd3 || (grid[y*WIDTH + x] && cnt == 4'd2);
    end
  end
  assign same = nxt == grid;
  // controller next state: start/load in IDLE, one generation per cycle in RUN
  always_comb begin
    state_n = state;
    grid_n = grid;
    rem_n = rem;
    gen_n = gen;
    stable_n = stable_q;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (bus.step_start) begin
        if (bus.step_count == '0) done_n = 1'b1;
        else begin
          rem_n = bus.step_count;
          state_n = RUN;
          stable_n = 1'b0;
        end
      end else if (bus.load_en) begin
        grid_n = {grid[N-2:0], bus.load_bit};
        gen_n = '0;
        stable_n = 1'b0;
      end
    end else begin
      grid_n = nxt;
      gen_n = gen + CNT_W'(1);
      rem_n = rem - CNT_W'(1);
      stable_n = same;
      if (rem == CNT_W'(1) || (STOP_ON_STABLE != 0 && same)) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
  end
  // controller and grid registers, frozen while en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grid <= '0;
      rem <= '0;
      gen <= '0;
      stable_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.en) begin
      state <= state_n;
      grid <= grid_n;
      rem <= rem_n;
      gen <= gen_n;
      stable_q <= stable_n;
      done_q <= done_n;
    end
  end
  // snapshot dump: capture the registered grid, then shift it out high index first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      dcnt <= '0;
    end else if (bus.en) begin
      if (dcnt != '0) begin
        shadow <= {shadow[N-2:0], 1'b0};
        dcnt <= dcnt - DW'(1);
      end else if (bus.dump_start) begin
        shadow <= grid;
        dcnt <= DW'(N);
      end
    end
  end
  assign dv = dcnt != '0;
  assign bus.out_bit = grid[N-1];
  assign bus.busy = state == RUN;
  assign bus.done = done_q;
  assign bus.stable = stable_q;
  assign bus.gen_count = gen;
  assign bus.dump_valid = dv;
  assign bus.dump_bit = dv & shadow[N-1];
endmodule

// File: tb/tb_cookie_grid.sv
// tb_cookie_grid: two cookie_grid instances (dead border + stop, torus + no stop) against a life model
module tb_cookie_grid;
  localparam int W = 7, H = 5, N = W * H, CW = 8;
  logic clk = 0, rst_n = 0, en = 0, load_en = 0, load_bit = 0, step_start = 0, dump_start = 0;
  logic [CW-1:0] step_count = '0;
  int checks = 0, failures = 0, bc;
  bit chk_on = 0;
  always #5 clk = ~clk;
  cookie_grid_if #(.CNT_W(CW)) i0 ();
  cookie_grid_if #(.CNT_W(CW)) i1 ();
  assign i0.en = en;
  assign i0.load_en = load_en;
  assign i0.load_bit = load_bit;
  assign i0.step_start = step_start;
  assign i0.step_count = step_count;
  assign i0.dump_start = dump_start;
  assign i1.en = en;
  assign i1.load_en = load_en;
  assign i1.load_bit = load_bit;
  assign i1.step_start = step_start;
  assign i1.step_count = step_count;
  assign i1.dump_start = dump_start;
  cookie_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(0), .STOP_ON_STABLE(1), .CNT_W(CW)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  cookie_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(1), .STOP_ON_STABLE(0), .CNT_W(CW)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  // behavioural model: grid as a bit vector, life rule on (x,y), dump as a queue of cells
  bit [N-1:0] mg[2];
  bit mrun[2], mdone[2], mstab[2];
  int mrem[2], mgen[2];
  bit mq[2][$];
  bit [N-1:0] cur, nx;
  function automatic bit [N-1:0] life(bit [N-1:0] g, bit wr);
    bit [N-1:0] r;
    int n, cx, cy;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            cx = x + dx;
            cy = y + dy;
            if (wr) begin
              cx = (cx + W) % W;
              cy = (cy + H) % H;
            end
            if ((dx != 0 || dy != 0) && cx >= 0 && cx < W && cy >= 0 && cy < H) n += int'(g[cy*W + cx]);
          end
        r[y*W + x] = (n == 3) || (g[y*W + x] && n == 2);
      end
    return r;
  endfunction
  function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d = -1, input int e = -1);
    logic [N-1:0] r;
    r = '0;
    r[a] = 1'b1;
    r[b] = 1'b1;
    r[c] = 1'b1;
    if (d >= 0) r[d] = 1'b1;
    if (e >= 0) r[e] = 1'b1;
    return r;
  endfunction
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mg[d] = '0;
        mrun[d] = 0;
        mdone[d] = 0;
        mstab[d] = 0;
        mrem[d] = 0;
        mgen[d] = 0;
        mq[d].delete();
      end else if (en) begin
        cur = mg[d];
        if (mq[d].size() > 0) void'(mq[d].pop_front());
        else if (dump_start) for (int i = N - 1; i >= 0; i--) mq[d].push_back(cur[i]);
        mdone[d] = 0;
        if (!mrun[d]) begin
          if (step_start) begin
            if (step_count == 0) mdone[d] = 1;
            else begin
              mrun[d] = 1;
              mrem[d] = int'(step_count);
              mstab[d] = 0;
            end
          end else if (load_en) begin
            mg[d] = {cur[N-2:0], load_bit};
            mgen[d] = 0;
            mstab[d] = 0;
          end
        end else begin
          nx = life(cur, d == 1);
          mstab[d] = nx == cur;
          mg[d] = nx;
          mgen[d] = (mgen[d] + 1) % (1 << CW);
          mrem[d]--;
          if (mrem[d] == 0 || (d == 0 && mstab[d])) begin
            mrun[d] = 0;
            mdone[d] = 1;
          end
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d), d ? i1.busy : i0.busy, mrun[d]);
      chk($sformatf("done%0d", d), d ? i1.done : i0.done, mdone[d]);
      chk($sformatf("stable%0d", d), d ? i1.stable : i0.stable, mstab[d]);
      chk($sformatf("gen%0d", d), d ? i1.gen_count : i0.gen_count, mgen[d]);
      chk($sformatf("out_bit%0d", d), d ? i1.out_bit : i0.out_bit, mg[d][N-1]);
      chk($sformatf("dump_valid%0d", d), d ? i1.dump_valid : i0.dump_valid, mq[d].size() > 0);
      chk($sformatf("dump_bit%0d", d), d ? i1.dump_bit : i0.dump_bit, mq[d].size() > 0 ? mq[d][0] : 1'b0);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (chk_on) compare();
  endtask
  task automatic load_pat(input logic [N-1:0] p);
    load_en = 1;
    for (int i = N - 1; i >= 0; i--) begin
      load_bit = p[i];
      tick();
    end
    load_en = 0;
    load_bit = 0;
  endtask
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while ((i0.busy || i1.busy) && cnt < 1000) begin
      cnt++;
      tick();
    end
    chk("idle_timeout", i0.busy | i1.busy, 0);
  endtask
  task automatic start(input int n);
    step_count = CW'(n);
    step_start = 1;
    tick();
    step_start = 0;
  endtask
  task automatic run(input int n, output int cnt);
    start(n);
    wait_idle(cnt);
  endtask
  task automatic grab(input int d, output logic [N-1:0] v);
    dump_start = 1;
    tick();
    dump_start = 0;
    for (int i = 0; i < N; i++) begin
      v[N-1-i] = d ? i1.dump_bit : i0.dump_bit;
      tick();
    end
  endtask
  logic [N-1:0] blink_h, blink_v, glider, block, got;
  initial begin
    blink_h = cells(16, 17, 18);
    blink_v = cells(10, 17, 24);
    glider = cells(1, 9, 14, 15, 16);
    block = cells(9, 10, 16, 17);
    en = 1;
    tick();
    chk_on = 1;
    chk("rst_busy", i0.busy, 0);
    chk("rst_gen", i1.gen_count, 0);
    chk("rst_dump_valid", i0.dump_valid, 0);
    rst_n = 1;
    tick();
    load_pat(blink_h);
    run(1, bc);
    chk("blink_busy_cycles", bc, 1);
    chk("blink_done", i0.done, 1);
    chk("blink_gen", i0.gen_count, 1);
    chk("blink_stable", i0.stable, 0);
    grab(0, got);
    chk("blink_grid", got, blink_v);
    start(0);
    chk("zero_done", i0.done, 1);
    chk("zero_busy", i1.busy, 0);
    load_en = 1;
    load_bit = 1;
    start(0);
    load_en = 0;
    load_bit = 0;
    chk("load_ignored_gen", i1.gen_count, 1);
    grab(1, got);
    chk("load_ignored_grid", got, blink_v);
    load_pat(glider);
    run(140, bc);
    chk("glider_busy_cycles", bc, 140);
    chk("glider_gen", i1.gen_count, 140);
    grab(1, got);
    chk("glider_grid", got, glider);
    load_pat(block);
    start(100);
    chk("block_busy", i0.busy, 1);
    tick();
    chk("block_done", i0.done, 1);
    chk("block_stable", i0.stable, 1);
    chk("block_gen", i0.gen_count, 1);
    wait_idle(bc);
    chk("block_gen_torus", i1.gen_count, 100);
    grab(0, got);
    chk("block_grid", got, block);
    load_pat(blink_h);
    start(10);
    tick();
    dump_start = 1;
    tick();
    dump_start = 0;
    wait_idle(bc);
    chk("dump_run_gen", i0.gen_count, 10);
    repeat (30) tick();
    load_pat(glider);
    start(20);
    repeat (3) tick();
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("freeze_busy", i1.busy, 1);
    end
    en = 1;
    wait_idle(bc);
    chk("freeze_gen", i1.gen_count, 20);
    load_pat(blink_h);
    start(10);
    repeat (3) tick();
    rst_n = 0;
    tick();
    chk("midrst_busy", i0.busy, 0);
    chk("midrst_done", i1.done, 0);
    chk("midrst_gen", i1.gen_count, 0);
    rst_n = 1;
    load_pat(glider);
    run(255, bc);
    chk("wrap_gen255", i1.gen_count, 255);
    run(2, bc);
    chk("wrap_gen1", i1.gen_count, 1);
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      rst_n = $urandom_range(0, 299) != 0;
      load_en = $urandom_range(0, 1) == 1;
      load_bit = $urandom_range(0, 1) == 1;
      step_start = $urandom_range(0, 19) == 0;
      step_count = CW'($urandom_range(0, 12));
      dump_start = $urandom_range(0, 29) == 0;
      tick();
    end
    {en, load_en, load_bit, step_start, dump_start} = 5'b10000;
    rst_n = 1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cookie_grid.md
Name: cookie_grid

Overview:
- Parametrised Game-of-Life cell array: WIDTH x HEIGHT cells, rule B3/S23.
- Serial load chain in, serial load chain out.
- Selectable edge mode: dead border or toroidal wrap.
- On-board run controller that advances N generations per command, with optional early stop on a stable pattern.
- Snapshot dump port that shifts the grid out while the array keeps running.
- Sits between the serial configuration loader and the display serialiser. Replaces the fixed 16x16 array in the next generation of the design.

Parameters:
WIDTH, 16, cells per row (>=3)
HEIGHT, 16, rows (>=3)
WRAP, 0, 0 = out-of-grid neighbours dead; 1 = toroidal (x and y wrap modulo WIDTH/HEIGHT)
STOP_ON_STABLE, 1, 1 = run ends early when a generation produces no change
CNT_W, 16, width of step_count and gen_count

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  global enable; low = all state (grid, FSM, counters, dump) holds
load_en  in  1  shift one load bit per cycle while controller IDLE
load_bit  in  1  serial load data into cell 0
out_bit  out  1  cell N-1 state (N=WIDTH*HEIGHT), for chaining
step_start  in  1  pulse: run step_count generations
step_count  in  CNT_W  generations to run, sampled with step_start
busy  out  1  controller in RUN
done  out  1  one-cycle pulse at end of run
stable  out  1  last computed generation equalled its predecessor
gen_count  out  CNT_W  generations executed since last load/reset, wraps
dump_start  in  1  pulse: snapshot grid and shift it out
dump_bit  out  1  serial snapshot data
dump_valid  out  1  high while dump_bit is meaningful

Behaviour:
- Cell index idx = y*WIDTH + x, row-major. Neighbours are the 8 cells at (x±1, y±1). Each edge-mode case either reads 0 or wraps, per WRAP.
- Next state: alive if (live neighbours == 3) or (alive and live neighbours == 2); otherwise dead.
- Reset, when rst_n is low at a clk edge:
  - grid all 0; controller IDLE; remaining 0.
  - gen_count 0; busy, done, stable 0.
  - dump idle; dump_bit 0, dump_valid 0.
- All state updates require en=1, except reset.
- Controller states: IDLE and RUN.
- IDLE:
  - step_start=1 and step_count=0: stay IDLE, done=1 next cycle, grid unchanged.
  - step_start=1 and step_count>0: remaining<=step_count, go to RUN, busy=1 next cycle, stable<=0.
  - Otherwise, if load_en=1: cell[0]<=load_bit, cell[i]<=cell[i-1] for i>0; gen_count<=0, stable<=0.
  - step_start has priority over load_en in the same cycle.
- RUN, each enabled edge:
  - grid<=next(grid); gen_count<=gen_count+1; remaining<=remaining-1.
  - stable<=(next==grid).
  - If remaining==1, or (STOP_ON_STABLE and next==grid): go to IDLE, busy<=0, done<=1.
  - A run of K generations with no early stop therefore has busy high for exactly K cycles and done coincident with busy falling.
  - step_start and load_en are ignored in RUN.
- done is high for one cycle only. It is cleared the following enabled cycle.
- Dump engine runs independently of the controller:
  - Accepted when not dumping: on dump_start, shadow<=current grid, as registered in the same cycle (pre-update value if RUN is also stepping). Counter<=N.
  - Following N cycles: dump_valid=1, dump_bit=shadow[N-1], shadow shifts toward higher index. Cell N-1 is emitted first, cell 0 last.
  - dump_start while dumping is ignored.
- en low mid-run or mid-dump freezes everything. Counting resumes exactly where it stopped.
- Reset mid-run or mid-dump aborts immediately, with reset values next cycle. No done pulse.
- gen_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- 5x5, WRAP=0: load a horizontal blinker at row 2, x=1..3, step_count=1 -> vertical blinker at x=2, y=1..3; busy high 1 cycle; done pulse; gen_count=1; stable=0.
- 8x8, WRAP=1, STOP_ON_STABLE=0: load a glider, step_count=32 -> grid identical to loaded pattern; busy high exactly 32 cycles; gen_count=32.
- 6x6, STOP_ON_STABLE=1: load a 2x2 block, step_count=100 -> done after 1 generation; stable=1; gen_count=1; grid unchanged.
- 5x5 blinker, step_count=10; dump_start on the 3rd RUN cycle -> 25 dump_valid cycles stream the grid as registered at that edge, cell 24 first; run completes unaffected with gen_count=10.
- Mid-run: drop en for 5 cycles -> busy stays high and grid/gen_count hold; total enabled RUN cycles still equal step_count.
- Reset mid-run -> all outputs 0 next cycle, no done. Separately: step_count=0 -> done pulse, grid unchanged; load_en with step_start in the same cycle -> load ignored.
